// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver (start, DBIT data LSB first, stop).
// Delivers bytes through a valid/ack holding register; flags framing and overrun.
module uart_rx_frame #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_s;
    logic [3:0] w_s_nxt;
    logic [2:0] r_n;
    logic [2:0] w_n_nxt;
    logic [7:0] r_b;
    logic [7:0] w_b_nxt;
    logic       r_sync1;
    logic       r_rxs;
    logic       w_load;
    logic       w_ferr;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_done;
    logic       r_ferr;
    logic       r_ovr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s     <= 4'd0;
            r_n     <= 3'd0;
            r_b     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            IDLE: begin
                // start-edge detection is not gated by s_tick
                if (!r_rxs) begin
                    w_state_nxt = START;
                    w_s_nxt     = 4'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == 4'd7) begin
                        w_s_nxt = 4'd0;
                        if (!r_rxs) begin
                            w_state_nxt = DATA;
                            w_n_nxt     = 3'd0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == 4'd15) begin
                        w_s_nxt = 4'd0;
                        w_b_nxt = {r_rxs, r_b[7:1]};
                        if (r_n == N_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + 3'd1;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_s_nxt     = 4'd0;
                        w_load      = r_rxs;
                        w_ferr      = !r_rxs;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // a load in the same cycle as rx_ack wins and is not an overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= w_load;
            r_ferr <= w_ferr;
            r_ovr  <= w_load && r_valid && !rx_ack;
            if (w_load) begin
                r_data  <= r_b >> (8 - DBIT);
                r_valid <= 1'b1;
            end else if (rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against an 8-bit and a 7-bit receiver.
// s_tick every 4 clk, so one bit period is 64 clk.
module tb_uart_rx_frame;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_ack  = 1'b0;
    logic       rx_drv  = 1'b1;
    logic       sel7    = 1'b0;
    logic [1:0] tc      = 2'd0;
    logic       s_tick;
    int         tick_no = 0;

    logic       rx8;
    logic       rx7;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
    logic [7:0] rx_data7;
    logic       rx_valid7;
    logic       rx_done7;
    logic       frame_err7;
    logic       overrun7;
    logic       rx_busy7;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int busy_cyc = 0;
    int done7_cnt = 0;

    always #5 clk = ~clk;

    assign s_tick = (tc == 2'd3);
    assign rx8    = sel7 ? 1'b1 : rx_drv;
    assign rx7    = sel7 ? rx_drv : 1'b1;

    always @(posedge clk) begin
        tc <= tc + 2'd1;
        if (s_tick) tick_no <= tick_no + 1;
    end

    always @(negedge clk) begin
        if (rx_done) done_cnt <= done_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (rx_busy) busy_cyc <= busy_cyc + 1;
        if (rx_done7) done7_cnt <= done7_cnt + 1;
    end

    uart_rx_frame #(.DBIT(8), .SB_TICK(16)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tick    (s_tick),
        .rx        (rx8),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    uart_rx_frame #(.DBIT(7), .SB_TICK(16)) u_dut7 (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tick    (s_tick),
        .rx        (rx7),
        .rx_data   (rx_data7),
        .rx_valid  (rx_valid7),
        .rx_ack    (rx_ack),
        .rx_done   (rx_done7),
        .frame_err (frame_err7),
        .overrun   (overrun7),
        .rx_busy   (rx_busy7)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Start is seen 3 clk after the falling edge; the load edge is then
    // the (8 + 16*nb + 16)-th tick edge, and ack_load strobes rx_ack in
    // exactly the cycle that edge samples.
    task automatic send(input logic [7:0] d, input int nb,
                        input bit stop_ok, input bit ack_load);
        int base;
        int bit_i;
        int pos;
        int last;
        base = 0;
        last = 8 + 16 * nb + 16;
        for (int cyc = 0; cyc < 64 * (nb + 2); cyc++) begin
            @(negedge clk);
            bit_i = cyc / 64;
            pos   = cyc % 64;
            if (bit_i == 0) rx_drv = 1'b0;
            else if (bit_i <= nb) rx_drv = d[bit_i-1];
            else rx_drv = stop_ok || (pos >= 48);
            if (cyc == 3) base = tick_no;
            if (ack_load)
                rx_ack = (cyc > 3) && (tick_no == base + last - 1) && s_tick;
        end
        rx_ack = 1'b0;
        rx_drv = 1'b1;
    endtask

    int d0;
    int f0;
    int o0;
    int b0;
    int bd;

    initial begin
        idle(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_pulses", {rx_done, frame_err, overrun}, 3'b000);
        reset_n = 1'b1;
        idle(10);

        d0 = done_cnt;
        f0 = ferr_cnt;
        send(8'hA5, 8, 1'b1, 1'b0);
        idle(4);
        check("nom_done", done_cnt - d0, 1);
        check("nom_data", rx_data, 8'hA5);
        check("nom_valid", rx_valid, 1'b1);
        check("nom_ferr", ferr_cnt - f0, 0);
        ack();
        check("nom_ack_clr", rx_valid, 1'b0);
        check("nom_ack_data", rx_data, 8'hA5);

        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_cyc;
        @(negedge clk);
        rx_drv = 1'b0;
        idle(20);
        rx_drv = 1'b1;
        idle(60);
        bd = busy_cyc - b0;
        check("glitch_busy_max", bd <= 32, 1);
        check("glitch_busy_min", bd >= 29, 1);
        check("glitch_busy_end", rx_busy, 1'b0);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        send(8'h11, 8, 1'b1, 1'b0);
        idle(4);
        check("fe_pre_data", rx_data, 8'h11);
        d0 = done_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send(8'h3C, 8, 1'b0, 1'b0);
        idle(80);
        check("fe_ferr", ferr_cnt - f0, 1);
        check("fe_done", done_cnt - d0, 0);
        check("fe_data", rx_data, 8'h11);
        check("fe_valid", rx_valid, 1'b1);
        check("fe_ovr", ovr_cnt - o0, 0);
        check("fe_busy", rx_busy, 1'b0);

        ack();
        d0 = done_cnt;
        o0 = ovr_cnt;
        send(8'h00, 8, 1'b1, 1'b0);
        check("ovr_first", rx_data, 8'h00);
        send(8'hFF, 8, 1'b1, 1'b0);
        idle(4);
        check("ovr_done", done_cnt - d0, 2);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_data", rx_data, 8'hFF);
        check("ovr_valid", rx_valid, 1'b1);

        ack();
        d0 = done_cnt;
        o0 = ovr_cnt;
        send(8'h00, 8, 1'b1, 1'b0);
        send(8'hFF, 8, 1'b1, 1'b1);
        idle(4);
        check("ackld_done", done_cnt - d0, 2);
        check("ackld_ovr", ovr_cnt - o0, 0);
        check("ackld_data", rx_data, 8'hFF);
        check("ackld_valid", rx_valid, 1'b1);

        d0 = done_cnt;
        fork
            send(8'h5A, 8, 1'b1, 1'b0);
            begin
                idle(288);
                check("rstm_busy_pre", rx_busy, 1'b1);
                reset_n = 1'b0;
                #1;
                check("rstm_data", rx_data, 8'h00);
                check("rstm_valid", rx_valid, 1'b0);
                check("rstm_busy", rx_busy, 1'b0);
                check("rstm_pulses", {rx_done, frame_err, overrun}, 3'b000);
            end
        join
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);
        check("rstm_no_done", done_cnt - d0, 0);
        send(8'hC3, 8, 1'b1, 1'b0);
        idle(4);
        check("rstm_next_data", rx_data, 8'hC3);
        check("rstm_next_valid", rx_valid, 1'b1);
        check("rstm_next_done", done_cnt - d0, 1);

        sel7 = 1'b1;
        d0 = done7_cnt;
        send(8'h55, 7, 1'b1, 1'b0);
        idle(4);
        check("d7_data", rx_data7, 8'h55);
        check("d7_bit7", rx_data7[7], 1'b0);
        check("d7_valid", rx_valid7, 1'b1);
        check("d7_done", done7_cnt - d0, 1);
        ack();
        send(8'h2A, 7, 1'b1, 1'b0);
        idle(4);
        check("d7_data2", rx_data7, 8'h2A);
        check("d7_ovr", overrun7, 1'b0);
        sel7 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

16×-oversampling UART receiver: the companion to the design's UART transmitter on the same `s_tick` baud-tick generator. Frame format is 1 start bit, DBIT data bits LSB first, 1 stop bit, no parity. The block synchronizes the serial line, validates the start bit at mid-bit, and samples data at bit centres. It delivers each byte through a holding register with a valid/ack handshake and flags framing and overrun errors.

## Interface
- DBIT, 8, data bits per frame; legal range 5..8.
- SB_TICK, 16, stop-bit sample point in ticks after the last data sample; legal range 1..16.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- s_tick  in  1  baud tick, one clk cycle wide, 16 per bit period.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last good byte, right-aligned; bits above DBIT-1 are 0.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- rx_done  out  1  one-cycle pulse when a good frame is loaded.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good frame overwrites an unacked byte.
- rx_busy  out  1  high while state ≠ IDLE.

## Operation
- Synchronizer: 2-flop chain on rx, both flops reset to 1; all decisions use the synchronized value rxs.
- Counters: 4-bit tick counter s, 3-bit bit counter n, 8-bit shift register b.
- FSM states IDLE, START, DATA, STOP. s, n and the state advance only on cycles with s_tick=1.
- IDLE: rxs=0 → START with s=0. Detection does not wait for s_tick.
- START: when s=7, rxs=0 → DATA with s=0, n=0. When s=7 and rxs=1, the pulse is a glitch → IDLE with no output. Otherwise s+1.
- DATA: when s=15, b={rxs,b[7:1]} and s=0. If n=DBIT-1 → STOP, otherwise n+1. Otherwise s+1.
- STOP: when s=SB_TICK-1 → IDLE, and the stop bit is checked:
  - rxs=1: rx_data=b>>(8-DBIT), rx_valid=1, rx_done pulse. If rx_valid was already 1 and rx_ack is not asserted in that same cycle, overrun also pulses and the old byte is lost.
  - rxs=0: frame_err pulses. rx_data and rx_valid are unchanged, and the FSM still returns to IDLE. If rxs is still 0 (break condition), START is entered on the next cycle.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - A load and rx_ack in the same cycle leave rx_valid=1 with the new byte, and overrun does not pulse.
- Reset (any time, including mid-frame): state IDLE, s=n=0, b=0, sync flops=1. Outputs are rx_data=0, rx_valid=0, rx_done=0, frame_err=0, overrun=0, rx_busy=0. Nothing is delivered for a frame in progress.

## Timing
- rx edge to rxs: 2 clk.
- Start-bit validation: 8 s_ticks after IDLE exits.
- Data bit k is sampled 16·(k+1) ticks after validation.
- Stop bit is sampled SB_TICK ticks after the last data bit.
- rx_done, frame_err and overrun assert on the clk edge after the stop-sample s_tick, for exactly 1 cycle. rx_data and rx_valid update on that same edge.
- With SB_TICK=16, the FSM returns to IDLE at mid-stop-bit. This tolerates back-to-back frames and ≈±3% baud mismatch.
- rx_busy follows the registered state, with no combinational path from rx.

## Test plan
- Nominal frame: s_tick every 4 clk, send 0xA5 with a good stop bit → 1 rx_done pulse, rx_data=0xA5, rx_valid=1; rx_ack then clears rx_valid.
- Glitch: rx low for 5 ticks, then high → no rx_done and no frame_err; rx_busy high for ≤8 ticks, then 0.
- Framing error: send 0x3C with the stop bit held low, while a previous 0x11 sits unacked → frame_err pulses once; rx_data stays 0x11; rx_valid stays 1; no rx_done.
- Overrun: back-to-back 0x00 then 0xFF with no rx_ack → 2 rx_done pulses; overrun pulses with the second; rx_data=0xFF. Repeat with rx_ack in the second load cycle → no overrun.
- Reset mid-frame: assert reset_n=0 during data bit 3 of 0x5A → all outputs 0 immediately. A following 0xC3 is received correctly.
- DBIT=7: send 7-bit value 0x55 → rx_data=0x55 with bit7=0.
